// File: rtl/riscv_inst_encoder_if.sv
// Request/imem bus for riscv_inst_encoder: field-level instruction requests in, imem write port out.
interface riscv_inst_encoder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_kind;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [2:0]        req_funct3;
    logic [6:0]        req_funct7;
    logic [31:0]       req_imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              imem_ack;

    modport slave (
        input  req_valid, req_kind, req_rd, req_rs1, req_rs2, req_funct3, req_funct7,
               req_imm, imem_ack,
        output req_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output req_valid, req_kind, req_rd, req_rs1, req_rs2, req_funct3, req_funct7,
               req_imm, imem_ack,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/riscv_inst_encoder.sv
// Assembles RV32I LOAD/OPIMM/STORE/OP/BRANCH words and streams them into imem via a FIFO.
// Optional immediate range checking is enabled by defining RANGE_CHECK_EN.
module riscv_inst_encoder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    riscv_inst_encoder_if.slave      bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err,
    output logic [7:0]               err_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [7:0]        err_count_q, err_count_d;

    logic [31:0] word_c;
    logic        legal_c;
    logic        accept_c;
    logic        push_c;
    logic        pop_c;

    // Field-to-word assembly; legal_c marks requests that produce a word.
    always_comb begin
        word_c  = '0;
        legal_c = 1'b1;
        case (bus.req_kind)
            3'd0: word_c = {bus.req_imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OPC_LOAD};
            3'd1: word_c = {bus.req_imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, OPC_OPIMM};
            3'd2: word_c = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                            bus.req_imm[4:0], OPC_STORE};
            3'd3: word_c = {bus.req_funct7, bus.req_rs2, bus.req_rs1, bus.req_funct3,
                            bus.req_rd, OPC_OP};
            3'd4: word_c = {bus.req_imm[12], bus.req_imm[10:5], bus.req_rs2, bus.req_rs1,
                            bus.req_funct3, bus.req_imm[4:1], bus.req_imm[11], OPC_BRANCH};
            default: legal_c = 1'b0;
        endcase
`ifdef RANGE_CHECK_EN
        case (bus.req_kind)
            3'd0, 3'd1, 3'd2:
                if (($signed(bus.req_imm) < -32'sd2048) || ($signed(bus.req_imm) > 32'sd2047))
                    legal_c = 1'b0;
            3'd4:
                if (($signed(bus.req_imm) < -32'sd4096) || ($signed(bus.req_imm) > 32'sd4094) ||
                    bus.req_imm[0])
                    legal_c = 1'b0;
            default: ;
        endcase
`endif
    end

`ifndef RANGE_CHECK_EN
    logic unused_imm_hi;
    assign unused_imm_hi = ^bus.req_imm[31:13];
`endif

    assign bus.req_ready = (count_q != FULL_CNT) && !clear;
    assign accept_c      = bus.req_valid && bus.req_ready;
    assign push_c        = accept_c && legal_c;
    assign pop_c         = (count_q != '0) && bus.imem_ack;

    // Next-state: clear wins over any push/pop in the same cycle.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        addr_d      = addr_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            addr_d      = BASE;
            err_count_d = '0;
        end else begin
            if (push_c) begin
                mem_d[wr_ptr_q] = word_c;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                addr_d   = addr_q + ADDR_W'(4);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (accept_c && !legal_c) begin
                err_d = 1'b1;
                if (err_count_q != 8'hFF)
                    err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= BASE;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign bus.imem_we    = (count_q != '0);
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = mem_q[rd_ptr_q];
    assign count          = count_q;
    assign err            = err_q;
    assign err_count      = err_count_q;
endmodule
